data_mem_arbiter: RTL and testbench

- Shares one single-port synchronous data memory (Lmem address bits, TAM-bit words, 1-cycle read latency) between Ncores core load/store ports.
- Round-robin arbitration with a one-transaction-at-a-time request/acknowledge handshake per core.
- Sits between the cores' load/store units and the data memory, replacing direct multi-port access.

---
 rtl/data_mem_arbiter_pkg.sv | 17 +
 rtl/data_mem_rr_pick.sv | 36 +++
 rtl/data_mem_arbiter.sv | 116 +++++++++++
 tb/tb_data_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and helpers for the data memory arbiter: FSM state encoding
// and the grant-index width calculation.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arbState_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int gidWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/data_mem_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning from ptr
// upward, modulo Ncores.
module data_mem_rr_pick #(
    parameter int Ncores = 2,
    parameter int GW     = 1
) (
    input  logic [Ncores-1:0] req,
    input  logic [GW-1:0]     ptr,
    output logic [GW-1:0]     winner,
    output logic              valid
);

    logic [GW-1:0]     candIdx [Ncores];
    logic [Ncores-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < Ncores; gi++) begin : g_cand
            assign candIdx[gi] = GW'((int'(ptr) + gi) % Ncores);
            assign hit[gi]     = req[candIdx[gi]];
        end
    endgenerate

    // Scan from the far end so the candidate nearest ptr is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = Ncores - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = candIdx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous data memory between
// Ncores load/store ports, one transaction at a time with a req/ack handshake.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int Ncores = 2,
    parameter int Lmem   = 8,
    parameter int TAM    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Ncores-1:0]             core_req,
    input  logic [Ncores-1:0]             core_we,
    input  logic [Ncores*TAM-1:0]         core_addr,
    input  logic [Ncores*TAM-1:0]         core_wdata,
    output logic [Ncores*TAM-1:0]         core_rdata,
    output logic [Ncores-1:0]             core_ack,
    output logic [Lmem-1:0]               mem_addr,
    output logic [TAM-1:0]                mem_din,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic [TAM-1:0]                mem_dout,
    output logic                          busy,
    output logic [gidWidth(Ncores)-1:0]   grant_id
);

    localparam int GW = gidWidth(Ncores);

    arbState_t       state;
    logic [GW-1:0]   ptr;
    logic            latchWe;
    logic [GW-1:0]   pickWinner;
    logic            pickValid;
    logic [TAM-1:0]  addrArr  [Ncores];
    logic [TAM-1:0]  wdataArr [Ncores];
    logic            unusedAddrBits;

    genvar gi;
    generate
        for (gi = 0; gi < Ncores; gi++) begin : g_slice
            assign addrArr[gi]  = core_addr[gi*TAM +: TAM];
            assign wdataArr[gi] = core_wdata[gi*TAM +: TAM];
        end
    endgenerate

    // Address bits above Lmem are deliberately ignored.
    assign unusedAddrBits = ^core_addr;

    data_mem_rr_pick #(
        .Ncores (Ncores),
        .GW     (GW)
    ) u_pick (
        .req    (core_req),
        .ptr    (ptr),
        .winner (pickWinner),
        .valid  (pickValid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            latchWe    <= 1'b0;
            core_ack   <= '0;
            core_rdata <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    core_ack <= '0;
                    if (pickValid) begin
                        // mem_addr/mem_din double as the latched request fields.
                        state    <= GRANT;
                        busy     <= 1'b1;
                        grant_id <= pickWinner;
                        latchWe  <= core_we[pickWinner];
                        mem_addr <= addrArr[pickWinner][Lmem-1:0];
                        mem_din  <= wdataArr[pickWinner];
                        mem_we   <= core_we[pickWinner];
                        mem_re   <= ~core_we[pickWinner];
                    end
                end
                GRANT: begin
                    mem_we <= 1'b0;
                    mem_re <= 1'b0;
                    if (latchWe) begin
                        state              <= ACK;
                        core_ack[grant_id] <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    core_rdata[int'(grant_id)*TAM +: TAM] <= mem_dout;
                    core_ack[grant_id] <= 1'b1;
                    state              <= ACK;
                end
                ACK: begin
                    core_ack <= '0;
                    ptr      <= (grant_id == GW'(Ncores - 1)) ? '0 : grant_id + 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  core_req;
    logic [1:0]  core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic [1:0]  core_ack;
    logic [7:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_dout;
    logic        busy;
    logic [0:0]  grant_id;

    int total;
    int bad;
    int bothHigh;

    logic [15:0] ram [0:255];

    data_mem_arbiter #(.Ncores(2), .Lmem(8), .TAM(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_ack   (core_ack),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        if (mem_re) mem_dout <= ram[mem_addr];
        if (mem_we && mem_re) bothHigh = bothHigh + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int c, input logic we, input logic [15:0] a, input logic [15:0] d);
        core_we[c]           = we;
        core_addr[c*16 +: 16]  = a;
        core_wdata[c*16 +: 16] = d;
        core_req[c]          = 1'b1;
    endtask

    // Issue one request from core c while in IDLE; returns edges to ack (-1 on timeout).
    task automatic runSingle(input int c, input logic we, input logic [15:0] a,
                             input logic [15:0] d, output int lat, output logic [15:0] rd);
        lat = -1;
        rd  = 16'h0;
        setReq(c, we, a, d);
        for (int n = 1; n <= 10; n++) begin
            step();
            if (core_ack[c]) begin
                lat = n;
                rd  = core_rdata[c*16 +: 16];
                break;
            end
        end
        core_req[c] = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if ({core_ack, mem_we, mem_re, busy, grant_id} !== 6'b0 || mem_addr !== 8'h0 ||
            mem_din !== 16'h0 || core_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: ack=%b we=%b re=%b busy=%b gid=%b addr=%h din=%h rdata=%h, required all zero",
                     core_ack, mem_we, mem_re, busy, grant_id, mem_addr, mem_din, core_rdata);
        end
        rst = 1'b0;
        step();
        setReq(0, 1'b0, 16'h0005, 16'h0);
        step();
        total++;
        if (mem_re !== 1'b1 || mem_addr !== 8'h05) begin
            bad++;
            $display("FAIL reset_grant_cmd: re=%b addr=%h, required re=1 addr=05", mem_re, mem_addr);
        end
        step();
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h0 ||
            core_ack !== 2'b00 || grant_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: busy=%b re=%b we=%b addr=%h ack=%b gid=%b, required all zero",
                     busy, mem_re, mem_we, mem_addr, core_ack, grant_id);
        end
        core_req = 2'b00;
        step();
        rst = 1'b0;
        begin
            int ackSeen;
            ackSeen = 0;
            for (int n = 0; n < 5; n++) begin
                step();
                if (core_ack !== 2'b00 || busy !== 1'b0) ackSeen++;
            end
            total++;
            if (ackSeen != 0) begin
                bad++;
                $display("FAIL reset_no_ack: %0d cycles with ack/busy, required 0", ackSeen);
            end
        end
    endtask

    task automatic test_contention();
        int lat;
        logic [15:0] rd;
        int order [2];
        int nAck;
        runSingle(0, 1'b1, 16'h0005, 16'h1111, lat, rd);
        runSingle(1, 1'b1, 16'h0006, 16'h2222, lat, rd);
        bothHigh = 0;
        nAck = 0;
        setReq(0, 1'b0, 16'h0005, 16'h0);
        setReq(1, 1'b0, 16'h0006, 16'h0);
        for (int n = 0; n < 20 && nAck < 2; n++) begin
            step();
            for (int c = 0; c < 2; c++) begin
                if (core_ack[c]) begin
                    order[nAck] = c;
                    nAck++;
                    total++;
                    if (core_rdata[c*16 +: 16] !== ((c == 0) ? 16'h1111 : 16'h2222) || grant_id !== 1'(c)) begin
                        bad++;
                        $display("FAIL contention_data core%0d: rdata=%h gid=%0d, required %h gid=%0d",
                                 c, core_rdata[c*16 +: 16], grant_id, (c == 0) ? 16'h1111 : 16'h2222, c);
                    end
                    core_req[c] = 1'b0;
                end
            end
        end
        step();
        total++;
        if (nAck != 2 || order[0] != 0 || order[1] != 1) begin
            bad++;
            $display("FAIL contention_order: acks=%0d order=%0d,%0d, required 2 acks order 0,1",
                     nAck, order[0], order[1]);
        end
        total++;
        if (bothHigh != 0) begin
            bad++;
            $display("FAIL contention_we_re: both high %0d cycles, required 0", bothHigh);
        end
    endtask

    task automatic test_fairness();
        int ackId [6];
        int ackCyc [6];
        int nAck;
        logic prevAck;
        nAck = 0;
        prevAck = 1'b0;
        setReq(0, 1'b0, 16'h0005, 16'h0);
        setReq(1, 1'b0, 16'h0006, 16'h0);
        for (int n = 0; n < 40 && nAck < 6; n++) begin
            step();
            if (prevAck) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL fairness_idle_gap: busy=%b after ack, required 0", busy);
                end
            end
            prevAck = 1'b0;
            if (core_ack != 2'b00) begin
                ackId[nAck]  = core_ack[1] ? 1 : 0;
                ackCyc[nAck] = n;
                nAck++;
                prevAck = 1'b1;
                if (nAck == 6) core_req = 2'b00;
            end
        end
        step();
        total++;
        if (nAck != 6 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fairness_count: acks=%0d busy=%b, required 6 acks then busy=0", nAck, busy);
        end
        for (int k = 0; k < nAck; k++) begin
            total++;
            if (ackId[k] != (k % 2) || (k > 0 && ackCyc[k] - ackCyc[k-1] != 4)) begin
                bad++;
                $display("FAIL fairness_seq[%0d]: core=%0d gap=%0d, required core=%0d gap=4",
                         k, ackId[k], (k > 0) ? ackCyc[k] - ackCyc[k-1] : 4, k % 2);
            end
        end
    endtask

    task automatic test_store_load();
        int lat;
        logic [15:0] rd;
        runSingle(0, 1'b1, 16'h0012, 16'hBEEF, lat, rd);
        total++;
        if (lat != 2) begin
            bad++;
            $display("FAIL store_latency: %0d, required 2", lat);
        end
        runSingle(0, 1'b0, 16'h0012, 16'h0, lat, rd);
        total++;
        if (lat != 3 || rd !== 16'hBEEF) begin
            bad++;
            $display("FAIL load_latency_data: lat=%0d rdata=%h, required lat=3 rdata=beef", lat, rd);
        end
        total++;
        if (core_rdata[31:16] !== 16'h2222) begin
            bad++;
            $display("FAIL rdata_hold_core1: %h, required 2222", core_rdata[31:16]);
        end
    endtask

    task automatic test_truncation();
        int lat;
        logic [15:0] rd;
        runSingle(1, 1'b1, 16'hFF03, 16'hA5A5, lat, rd);
        total++;
        if (lat != 2 || ram[8'h03] !== 16'hA5A5) begin
            bad++;
            $display("FAIL trunc_store: lat=%0d ram[03]=%h, required lat=2 a5a5", lat, ram[8'h03]);
        end
        runSingle(1, 1'b0, 16'h0003, 16'h0, lat, rd);
        total++;
        if (lat != 3 || rd !== 16'hA5A5) begin
            bad++;
            $display("FAIL trunc_load: lat=%0d rdata=%h, required lat=3 a5a5", lat, rd);
        end
        total++;
        if (core_rdata[15:0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL rdata_hold_core0: %h, required beef", core_rdata[15:0]);
        end
    endtask

    task automatic test_early_drop();
        int extra;
        setReq(1, 1'b0, 16'h0006, 16'h0);
        step();
        total++;
        if (mem_re !== 1'b1 || mem_addr !== 8'h06 || grant_id !== 1'b1) begin
            bad++;
            $display("FAIL drop_grant: re=%b addr=%h gid=%b, required re=1 addr=06 gid=1",
                     mem_re, mem_addr, grant_id);
        end
        core_req[1] = 1'b0;
        step();
        step();
        total++;
        if (core_ack !== 2'b10 || core_rdata[31:16] !== 16'h2222) begin
            bad++;
            $display("FAIL drop_ack: ack=%b rdata=%h, required ack=10 rdata=2222",
                     core_ack, core_rdata[31:16]);
        end
        extra = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (core_ack !== 2'b00 || busy !== 1'b0 || mem_re !== 1'b0) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL drop_no_retrigger: %0d active cycles, required 0", extra);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        bothHigh   = 0;
        rst        = 1'b1;
        core_req   = 2'b00;
        core_we    = 2'b00;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        test_reset();
        test_contention();
        test_fairness();
        test_store_load();
        test_truncation();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
